// File: rtl/soc_lane_scheduler.sv
// soc_lane_scheduler: issues sum-of-cubes cube-root candidates Q = 0..q_limit
// in ascending order to NUM_LANES parallel search lanes. It tracks lane
// occupancy, reclaims lanes that stay busy for TIMEOUT cycles, and stops at
// the first hit or when the candidates run out.
// Optional feature macro: SOC_SCHED_STATS_EN adds the dispatch, timeout and
// busy-cycle statistics counters and their ports.
module soc_lane_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int QW        = 16,
    parameter int RW        = 64,
    parameter int TIMEOUT   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              target,
    input  logic [QW-1:0]           q_limit,
    output logic [NUM_LANES-1:0]    lane_start,
    output logic [NUM_LANES*QW-1:0] lane_q,
    output logic [7:0]              lane_target,
    input  logic [NUM_LANES-1:0]    lane_done,
    input  logic [NUM_LANES-1:0]    lane_hit,
    input  logic [NUM_LANES*RW-1:0] lane_result,
    output logic                    busy,
    output logic                    found,
    output logic [RW-1:0]           result,
    output logic [QW-1:0]           result_q,
    output logic                    exhausted,
    output logic                    done
`ifdef SOC_SCHED_STATS_EN
    ,
    output logic [31:0]             stat_dispatched,
    output logic [15:0]             stat_timeouts,
    output logic [31:0]             stat_cycles
`endif
);

    localparam int LIW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW  = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [QW:0]   Q_ONE   = (QW+1)'(1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DISPATCH = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;
    localparam logic [1:0] S_FINISH   = 2'd3;

    logic [1:0]           r_state;
    logic [NUM_LANES-1:0] r_lane_busy;
    // One bit wider than a candidate so q_limit = 2^QW-1 ends without wrapping.
    logic [QW:0]          r_next_q;
    logic [QW-1:0]        r_q_limit;
    logic [CW-1:0]        r_tcnt [NUM_LANES];

    logic [NUM_LANES-1:0] w_done_q;
    logic [NUM_LANES-1:0] w_timeout;
    logic [NUM_LANES-1:0] w_hit;
    logic [NUM_LANES-1:0] w_disp_mask;
    logic [LIW-1:0]       w_free_idx;
    logic [LIW-1:0]       w_hit_idx;
    logic                 w_has_free;
    logic                 w_any_hit;
    logic                 w_q_avail;
    logic                 w_all_idle;
    logic                 w_accept;
    logic                 w_dispatch;

    // Lane completion/timeout qualification and lowest-index free/hit lane selection.
    always_comb begin
        w_done_q   = lane_done & r_lane_busy;
        w_hit      = w_done_q & lane_hit;
        w_any_hit  = |w_hit;
        w_has_free = |(~r_lane_busy);
        w_all_idle = (r_lane_busy == '0);
        w_q_avail  = (r_next_q <= {1'b0, r_q_limit});
        w_accept   = (r_state == S_IDLE) && start;
        w_dispatch = (r_state == S_DISPATCH) && !w_any_hit && w_q_avail && w_has_free;
        w_free_idx = '0;
        w_hit_idx  = '0;
        w_timeout  = '0;
        w_disp_mask = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            w_free_idx = r_lane_busy[i] ? w_free_idx : LIW'(i);
            w_hit_idx  = w_hit[i] ? LIW'(i) : w_hit_idx;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            // A done in the timeout cycle wins: it is a normal completion.
            w_timeout[i]   = r_lane_busy[i] && !lane_done[i] && (r_tcnt[i] == TMAX);
            w_disp_mask[i] = w_dispatch && (w_free_idx == LIW'(i));
        end
    end

    // Per-lane busy-age counters, restarted on every dispatch to that lane.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (reset) begin
                r_tcnt[i] <= '0;
            end else if (w_disp_mask[i]) begin
                r_tcnt[i] <= '0;
            end else if (r_lane_busy[i] && (r_tcnt[i] != TMAX)) begin
                r_tcnt[i] <= r_tcnt[i] + CNT_ONE;
            end else begin
                r_tcnt[i] <= r_tcnt[i];
            end
        end
    end

    // Search sequencing: accept, dispatch, hit capture, drain and finish pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_lane_busy <= '0;
            r_next_q    <= '0;
            r_q_limit   <= '0;
            lane_start  <= '0;
            lane_q      <= '0;
            lane_target <= 8'd0;
            busy        <= 1'b0;
            found       <= 1'b0;
            result      <= '0;
            result_q    <= '0;
            exhausted   <= 1'b0;
            done        <= 1'b0;
        end else begin
            lane_start  <= w_disp_mask;
            done        <= 1'b0;
            // Freed lanes only become dispatchable from the following cycle.
            r_lane_busy <= (r_lane_busy & ~w_done_q & ~w_timeout) | w_disp_mask;
            if (w_dispatch) begin
                lane_q[w_free_idx*QW +: QW] <= r_next_q[QW-1:0];
                r_next_q                    <= r_next_q + Q_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        lane_target <= target;
                        r_q_limit   <= q_limit;
                        r_next_q    <= '0;
                        found       <= 1'b0;
                        exhausted   <= 1'b0;
                        result      <= '0;
                        result_q    <= '0;
                        busy        <= 1'b1;
                        r_state     <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    if (w_any_hit) begin
                        found    <= 1'b1;
                        result   <= lane_result[w_hit_idx*RW +: RW];
                        result_q <= lane_q[w_hit_idx*QW +: QW];
                        r_state  <= S_DRAIN;
                    end else if (!w_q_avail && w_all_idle) begin
                        exhausted <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= S_FINISH;
                    end
                end
                S_DRAIN: begin
                    if (w_all_idle) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SOC_SCHED_STATS_EN
    logic [4:0]  w_to_cnt;
    logic [16:0] w_to_sum;

    // Number of lanes reclaimed by timeout this cycle, added with saturation.
    always_comb begin
        w_to_cnt = 5'd0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_to_cnt = w_to_cnt + {4'd0, w_timeout[i]};
        end
        w_to_sum = {1'b0, stat_timeouts} + {12'd0, w_to_cnt};
    end

    // Saturating statistics, cleared on accepted start and held after done.
    always_ff @(posedge clk) begin
        if (reset || w_accept) begin
            stat_dispatched <= 32'd0;
            stat_timeouts   <= 16'd0;
            stat_cycles     <= 32'd0;
        end else begin
            if (w_dispatch && (stat_dispatched != 32'hFFFF_FFFF)) begin
                stat_dispatched <= stat_dispatched + 32'd1;
            end
            stat_timeouts <= w_to_sum[16] ? 16'hFFFF : w_to_sum[15:0];
            if (busy && (stat_cycles != 32'hFFFF_FFFF)) begin
                stat_cycles <= stat_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
